// File: rtl/matrix_accelerator_soc_top.sv
// Bring-up SoC shell for the matrix accelerator: a command sequencer runs 64-bit command
// words out of on-chip RAM and drives a small control-register block and an 8N1 UART.

module soc_dram #(
    parameter int unsigned DEPTH      = 8192,
    parameter int unsigned IDX_W      = 13,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    re,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata
);
    logic [DATA_WIDTH-1:0] init_val [0:DEPTH-1];

    // registered read port and byte-enabled write port; contents survive reset
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= init_val[ridx];
        end
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (we && be[b]) begin
                init_val[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

module soc_ram #(
    parameter int unsigned      ADDR_WIDTH = 32,
    parameter int unsigned      DATA_WIDTH = 64,
    parameter logic [31:0]      RAM_BASE   = 32'h8000_0000,
    parameter logic [31:0]      RAM_LENGTH = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata
);
    localparam int unsigned BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W  = $clog2(RAM_LENGTH / (DATA_WIDTH / 8));

    logic [ADDR_WIDTH-1:0] roff_s;
    logic [ADDR_WIDTH-1:0] woff_s;
    logic [7:0]            be_s;
    logic                  unused_bits_s;

    assign roff_s = raddr - RAM_BASE;
    assign woff_s = waddr - RAM_BASE;
    // address bit 2 picks which 32-bit half of the word a store lands in
    assign be_s   = woff_s[2] ? 8'hF0 : 8'h0F;
    assign unused_bits_s = ^{roff_s[ADDR_WIDTH-1:IDX_W+BYTE_W], roff_s[BYTE_W-1:0],
                             woff_s[ADDR_WIDTH-1:IDX_W+BYTE_W], woff_s[1:0]};

    soc_dram #(.DEPTH(2 ** IDX_W), .IDX_W(IDX_W), .DATA_WIDTH(DATA_WIDTH)) i_dram (
        .clk   (clk),
        .re    (re),
        .ridx  (roff_s[IDX_W+BYTE_W-1:BYTE_W]),
        .rdata (rdata),
        .we    (we),
        .widx  (woff_s[IDX_W+BYTE_W-1:BYTE_W]),
        .be    (be_s),
        .wdata ({wdata, wdata})
    );
endmodule

module soc_ctrl_regs #(
    parameter int unsigned PRF_LOG_P = 1,
    parameter int unsigned PRF_LOG_Q = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [31:0] reg_q_o [0:3]
);
    localparam logic [31:0] PRF_ID = {24'h00_0000, 4'(PRF_LOG_P), 4'(PRF_LOG_Q)};

    // register file; a received byte outranks a clearing store to reg 2
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q_o[0] <= 32'h0000_0000;
            reg_q_o[1] <= PRF_ID;
            reg_q_o[2] <= 32'h0000_0000;
            reg_q_o[3] <= 32'h0000_0000;
        end else begin
            reg_q_o[1] <= PRF_ID;
            if (we && waddr == 2'd0) reg_q_o[0] <= wdata;
            if (we && waddr == 2'd3) reg_q_o[3] <= wdata;
            if (rx_valid) begin
                reg_q_o[2] <= {23'h00_0000, 1'b1, rx_byte};
            end else if (we && waddr == 2'd2) begin
                reg_q_o[2] <= {23'h00_0000, 1'b0, reg_q_o[2][7:0]};
            end
        end
    end
endmodule

module soc_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);
    localparam int unsigned     CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    tx_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;

    assign busy = (state_r != TX_IDLE);

    // frame shifter: tx is a register so it never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= TX_IDLE;
            cnt_r     <= CNT_W'(0);
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx        <= 1'b1;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    tx    <= 1'b1;
                    cnt_r <= CNT_W'(0);
                    if (start) begin
                        state_r <= TX_START;
                        shift_r <= data;
                        tx      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (cnt_r == LAST) begin
                        cnt_r     <= CNT_W'(0);
                        bit_idx_r <= 3'd0;
                        tx        <= shift_r[0];
                        state_r   <= TX_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (cnt_r == LAST) begin
                        cnt_r <= CNT_W'(0);
                        if (bit_idx_r == 3'd7) begin
                            tx      <= 1'b1;
                            state_r <= TX_STOP;
                        end else begin
                            tx        <= shift_r[1];
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (cnt_r == LAST) begin
                        cnt_r   <= CNT_W'(0);
                        state_r <= TX_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= TX_IDLE;
                    tx      <= 1'b1;
                end
            endcase
        end
    end
endmodule

module soc_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       valid,
    output logic [7:0] data
);
    localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    rx_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             rx_meta_r, rx_sync_r, rx_prev_r;

    // two-flop synchronizer plus one cycle of history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // half a bit after the falling edge re-checks start, then samples every full bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= RX_IDLE;
            cnt_r     <= CNT_W'(0);
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            valid     <= 1'b0;
            data      <= 8'h00;
        end else begin
            valid <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    cnt_r <= CNT_W'(0);
                    if (rx_prev_r && !rx_sync_r) state_r <= RX_START;
                end
                RX_START: begin
                    if (cnt_r == HALF) begin
                        cnt_r     <= CNT_W'(0);
                        bit_idx_r <= 3'd0;
                        state_r   <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_r == LAST) begin
                        cnt_r   <= CNT_W'(0);
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) state_r <= RX_STOP;
                        else bit_idx_r <= bit_idx_r + 3'd1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_r == LAST) begin
                        cnt_r   <= CNT_W'(0);
                        state_r <= RX_IDLE;
                        if (rx_sync_r) begin
                            valid <= 1'b1;
                            data  <= shift_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: state_r <= RX_IDLE;
            endcase
        end
    end
endmodule

module matrix_accelerator_soc_top #(
    parameter int unsigned PRF_LOG_P    = 1,
    parameter int unsigned PRF_LOG_Q    = 2,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter logic [31:0] RAM_BASE     = 32'h8000_0000,
    parameter logic [31:0] RAM_LENGTH   = 32'h0001_0000,
    parameter logic [31:0] CTRL_BASE    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tx,
    input  logic rx
);
    localparam logic [7:0]  OP_STORE = 8'h01;
    localparam logic [7:0]  OP_PUTC  = 8'h02;
    localparam logic [7:0]  OP_JUMP  = 8'h03;
    localparam logic [7:0]  OP_HALT  = 8'hFF;
    localparam logic [31:0] FETCH_ERR = 32'hFFFF_FFFE;

    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_EXEC, S_SFETCH, S_SWAIT, S_PUTC, S_HALT} seq_state_e;
    seq_state_e state_r, state_s;

    logic [ADDR_WIDTH-1:0] pc_r, pc_plus8_s, ram_raddr_s;
    logic [DATA_WIDTH-1:0] cmd_r, ram_rdata_s;
    logic [7:0]            opcode_s;
    logic [31:0]           operand_s, ctrl_wdata_s;
    logic [1:0]            ctrl_waddr_s;
    logic                  pc_in_ram_s, nxt_in_ram_s, st_ram_s, st_ctrl_s;
    logic                  ram_re_s, ram_we_s, ctrl_we_s, tx_start_s, tx_busy_s;
    logic                  rx_valid_s;
    logic [7:0]            rx_byte_s;
    logic [31:0]           ctrl_q_s [0:3];
    logic                  unused_bits_s;

    assign opcode_s     = cmd_r[63:56];
    assign operand_s    = cmd_r[31:0];
    assign pc_plus8_s   = pc_r + 32'd8;
    // offset compares stay correct across the 2^32 wrap
    assign pc_in_ram_s  = (pc_r - RAM_BASE) < RAM_LENGTH;
    assign nxt_in_ram_s = (pc_plus8_s - RAM_BASE) < RAM_LENGTH;
    assign st_ram_s     = (operand_s - RAM_BASE) < RAM_LENGTH;
    assign st_ctrl_s    = (operand_s - CTRL_BASE) < 32'd16;
    assign unused_bits_s = ^{cmd_r[55:32], ctrl_q_s[0], ctrl_q_s[1], ctrl_q_s[2], ctrl_q_s[3]};

    // sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_FETCH;
        else     state_r <= state_s;
    end

    // sequencer next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_FETCH:  if (pc_in_ram_s) state_s = S_WAIT; else state_s = S_HALT;
            S_WAIT:   state_s = S_EXEC;
            S_EXEC: begin
                case (opcode_s)
                    OP_STORE: state_s = S_SFETCH;
                    OP_PUTC:  state_s = S_PUTC;
                    OP_HALT:  state_s = S_HALT;
                    default:  state_s = S_FETCH;
                endcase
            end
            S_SFETCH: if (nxt_in_ram_s) state_s = S_SWAIT; else state_s = S_HALT;
            S_SWAIT:  state_s = S_FETCH;
            S_PUTC:   if (tx_busy_s) state_s = S_PUTC; else state_s = S_FETCH;
            S_HALT:   state_s = S_HALT;
            default:  state_s = S_FETCH;
        endcase
    end

    // sequencer outputs: RAM/CTRL strobes and UART start
    always_comb begin
        ram_re_s     = 1'b0;
        ram_raddr_s  = pc_r;
        ram_we_s     = 1'b0;
        ctrl_we_s    = 1'b0;
        ctrl_waddr_s = operand_s[3:2];
        ctrl_wdata_s = ram_rdata_s[31:0];
        tx_start_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (pc_in_ram_s) begin
                    ram_re_s = 1'b1;
                end else begin
                    ctrl_we_s    = 1'b1;
                    ctrl_waddr_s = 2'd0;
                    ctrl_wdata_s = FETCH_ERR;
                end
            end
            S_SFETCH: begin
                if (nxt_in_ram_s) begin
                    ram_re_s    = 1'b1;
                    ram_raddr_s = pc_plus8_s;
                end else begin
                    ctrl_we_s    = 1'b1;
                    ctrl_waddr_s = 2'd0;
                    ctrl_wdata_s = FETCH_ERR;
                end
            end
            S_SWAIT: begin
                if (st_ram_s) begin
                    ram_we_s = 1'b1;
                end else if (st_ctrl_s) begin
                    ctrl_we_s = 1'b1;
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            S_PUTC: begin
                if (tx_busy_s) tx_start_s = 1'b0;
                else           tx_start_s = 1'b1;
            end
            default: ram_re_s = 1'b0;
        endcase
    end

    // program counter and latched command word
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r  <= RAM_BASE;
            cmd_r <= 64'h0;
        end else begin
            if (state_r == S_WAIT) cmd_r <= ram_rdata_s;
            case (state_r)
                S_EXEC: begin
                    case (opcode_s)
                        OP_JUMP:                   pc_r <= operand_s;
                        OP_STORE, OP_PUTC, OP_HALT: pc_r <= pc_r;
                        default:                   pc_r <= pc_plus8_s;
                    endcase
                end
                S_SWAIT: pc_r <= pc_r + 32'd16;
                S_PUTC:  if (!tx_busy_s) pc_r <= pc_plus8_s;
                default: pc_r <= pc_r;
            endcase
        end
    end

    soc_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .RAM_BASE(RAM_BASE),
              .RAM_LENGTH(RAM_LENGTH)) i_ram (
        .clk   (clk),
        .re    (ram_re_s),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s),
        .we    (ram_we_s),
        .waddr (operand_s),
        .wdata (ram_rdata_s[31:0])
    );

    soc_ctrl_regs #(.PRF_LOG_P(PRF_LOG_P), .PRF_LOG_Q(PRF_LOG_Q)) i_ctrl_regs (
        .clk      (clk),
        .rst      (rst),
        .we       (ctrl_we_s),
        .waddr    (ctrl_waddr_s),
        .wdata    (ctrl_wdata_s),
        .rx_valid (rx_valid_s),
        .rx_byte  (rx_byte_s),
        .reg_q_o  (ctrl_q_s)
    );

    soc_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) i_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start_s),
        .data  (operand_s[7:0]),
        .busy  (tx_busy_s),
        .tx    (tx)
    );

    soc_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) i_uart_rx (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .valid (rx_valid_s),
        .data  (rx_byte_s)
    );
endmodule

// File: tb/tb_matrix_accelerator_soc_top.sv
// Directed bench for matrix_accelerator_soc_top: programs are preloaded through the RAM
// backdoor under reset, then CTRL registers, RAM words and the UART line are checked.

module tb_matrix_accelerator_soc_top;
    localparam logic [31:0] RB   = 32'h8000_0000;
    localparam logic [63:0] HALT = 64'hFF00_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;
    int   n_cmp = 0;
    int   n_err = 0;

    matrix_accelerator_soc_top dut (.clk(clk), .rst(rst), .tx(tx), .rx(rx));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] cmd(input logic [7:0] op, input logic [31:0] opr);
        return {op, 24'h00_0000, opr};
    endfunction

    task automatic poke(input int idx, input logic [63:0] v);
        dut.i_ram.i_dram.init_val[idx] <= v;
    endtask

    task automatic load_begin();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 80; i++) poke(i, HALT);
    endtask

    task automatic load_end();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int k = 0;
        while (tx !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(k < 300), 64'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        repeat (16) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_byte;
        int n;

        // STORE to CTRL reg 0, then a second STORE proves execution continues
        load_begin();
        poke(0, cmd(8'h01, 32'h0000_1000));
        poke(1, 64'h0000_0000_0000_00FF);
        poke(2, cmd(8'h01, 32'h0000_100C));
        poke(3, 64'h0000_0000_0000_0077);
        load_end();
        check_eq("rst_tx", 64'(tx), 64'd1);
        check_eq("rst_pc", 64'(dut.pc_r), 64'(RB));
        check_eq("rst_reg0", 64'(dut.i_ctrl_regs.reg_q_o[0]), 64'h0);
        check_eq("rst_reg1", 64'(dut.i_ctrl_regs.reg_q_o[1]), 64'h12);
        check_eq("rst_reg2", 64'(dut.i_ctrl_regs.reg_q_o[2]), 64'h0);
        check_eq("rst_reg3", 64'(dut.i_ctrl_regs.reg_q_o[3]), 64'h0);
        repeat (60) @(negedge clk);
        check_eq("store_reg0", 64'(dut.i_ctrl_regs.reg_q_o[0]), 64'hFF);
        check_eq("store_reg3", 64'(dut.i_ctrl_regs.reg_q_o[3]), 64'h77);
        check_eq("halt_pc_t1", 64'(dut.pc_r), 64'(RB + 32'h20));

        // RAM half-word stores, read-only reg 1, and a dropped store
        load_begin();
        poke(32'h20, 64'hAAAA_BBBB_CCCC_DDDD);
        poke(32'h21, 64'hAAAA_BBBB_CCCC_DDDD);
        poke(0, cmd(8'h01, RB + 32'h104));
        poke(1, 64'h0000_0000_1234_5678);
        poke(2, cmd(8'h01, RB + 32'h108));
        poke(3, 64'hDEAD_0000_9999_0001);
        poke(4, cmd(8'h01, 32'h0000_1004));
        poke(5, 64'h0000_0000_0000_0055);
        poke(6, cmd(8'h01, 32'h0000_2000));
        poke(7, 64'h0000_0000_0000_0066);
        load_end();
        repeat (80) @(negedge clk);
        check_eq("ram_upper", dut.i_ram.i_dram.init_val[32'h20], 64'h1234_5678_CCCC_DDDD);
        check_eq("ram_lower", dut.i_ram.i_dram.init_val[32'h21], 64'hAAAA_BBBB_9999_0001);
        check_eq("reg1_ro", 64'(dut.i_ctrl_regs.reg_q_o[1]), 64'h12);
        check_eq("drop_reg0", 64'(dut.i_ctrl_regs.reg_q_o[0]), 64'h0);
        check_eq("drop_reg3", 64'(dut.i_ctrl_regs.reg_q_o[3]), 64'h0);
        check_eq("halt_pc_t2", 64'(dut.pc_r), 64'(RB + 32'h40));

        // JUMP skips the intervening stores
        load_begin();
        poke(0, cmd(8'h03, RB + 32'h40));
        poke(1, cmd(8'h01, 32'h0000_100C));
        poke(2, 64'h0000_0000_0000_0099);
        poke(3, cmd(8'h01, 32'h0000_1000));
        poke(4, 64'h0000_0000_0000_0005);
        load_end();
        repeat (40) @(negedge clk);
        check_eq("jump_reg3", 64'(dut.i_ctrl_regs.reg_q_o[3]), 64'h0);
        check_eq("jump_reg0", 64'(dut.i_ctrl_regs.reg_q_o[0]), 64'h0);
        check_eq("jump_pc", 64'(dut.pc_r), 64'(RB + 32'h40));

        // PUTC 'A' then HALT: check frame shape and silence afterwards
        load_begin();
        poke(0, cmd(8'h02, 32'h0000_0041));
        load_end();
        wait_tx_low("putc_start_seen");
        n = 0;
        while (tx === 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check_eq("putc_start_len", 64'(n), 64'd16);
        exp_byte = 8'h41;
        repeat (8) @(negedge clk);
        check_eq("putc_bit0", 64'(tx), 64'(exp_byte[0]));
        for (int i = 1; i < 8; i++) begin
            repeat (16) @(negedge clk);
            check_eq($sformatf("putc_bit%0d", i), 64'(tx), 64'(exp_byte[i]));
        end
        repeat (16) @(negedge clk);
        check_eq("putc_stop", 64'(tx), 64'd1);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) n++;
        end
        check_eq("putc_quiet", 64'(n), 64'd0);
        check_eq("putc_pc", 64'(dut.pc_r), 64'(RB + 32'h8));

        // UART RX into reg 2, clear via store, bad stop bit discarded
        load_begin();
        poke(0, cmd(8'h03, RB));
        load_end();
        repeat (5) @(negedge clk);
        send_rx(8'h5A, 1'b1);
        repeat (40) @(negedge clk);
        check_eq("rx_reg2", 64'(dut.i_ctrl_regs.reg_q_o[2]), 64'h15A);
        poke(1, 64'h0);
        poke(0, cmd(8'h01, 32'h0000_1008));
        repeat (30) @(negedge clk);
        check_eq("rx_clear", 64'(dut.i_ctrl_regs.reg_q_o[2]), 64'h05A);
        send_rx(8'h33, 1'b0);
        repeat (40) @(negedge clk);
        check_eq("rx_bad_stop", 64'(dut.i_ctrl_regs.reg_q_o[2]), 64'h05A);

        // JUMP outside RAM halts with the fetch-error code
        load_begin();
        poke(0, cmd(8'h03, 32'h0000_0000));
        load_end();
        repeat (20) @(negedge clk);
        check_eq("oob_reg0", 64'(dut.i_ctrl_regs.reg_q_o[0]), 64'hFFFF_FFFE);
        check_eq("oob_pc", 64'(dut.pc_r), 64'h0);
        check_eq("oob_tx", 64'(tx), 64'd1);

        // reset in the middle of a frame
        load_begin();
        poke(0, cmd(8'h02, 32'h0000_0000));
        load_end();
        wait_tx_low("midrst_start_seen");
        repeat (20) @(negedge clk);
        check_eq("midrst_low", 64'(tx), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_tx", 64'(tx), 64'd1);
        check_eq("midrst_pc", 64'(dut.pc_r), 64'(RB));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
